// File: rtl/mux_pkg.sv
// Shared constants for the channel mux/arbiter: selection modes, counter sizing, default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_pkg;

    // Selection modes driven on the modo input
    localparam logic MODO_FIXO = 1'b0;
    localparam logic MODO_RR   = 1'b1;

    // Per-channel transfer counter sizing (optional counters)
    localparam int          CONT_W   = 16;
    localparam logic [15:0] CONT_MAX = 16'hFFFF;

    // Default data width per channel
    localparam int LARGURA_PADRAO = 32;

endpackage

// File: rtl/rr_arbitro.sv
// Round-robin grant: first requesting channel after ptr, scanning ptr+1, ptr+2, ... modulo CANAIS.
// Latency: purely combinational.
// Backpressure: none here; the caller gates the grant with its own accept condition.
module rr_arbitro #(
    parameter  int CANAIS = 4,
    localparam int SEL_W  = $clog2(CANAIS)
) (
    input  logic [CANAIS-1:0] pedido,
    input  logic [SEL_W-1:0]  ptr,
    output logic [CANAIS-1:0] concede,
    output logic [SEL_W-1:0]  indice,
    output logic              tem_concessao
);

    // Scan from the lowest priority (ptr itself) to the highest (ptr+1) so the last hit wins
    always_comb begin
        concede       = '0;
        indice        = '0;
        tem_concessao = 1'b0;
        for (int k = CANAIS; k >= 1; k--) begin
            if (pedido[(int'(ptr) + k) % CANAIS]) begin
                concede                                = '0;
                concede[(int'(ptr) + k) % CANAIS]      = 1'b1;
                indice                                 = SEL_W'((int'(ptr) + k) % CANAIS);
                tem_concessao                          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// Selects one of CANAIS valid/ready channels (fixed select or round-robin) into a registered output; MUX_ARB_CONTADORES_EN adds saturating per-channel transfer counters.
// Latency: 1 clock from input handshake to saida_valida; 1 word/clock sustained.
// Backpressure: input ready only when the output register is empty or draining; stall holds saida/canal_saida.
module mux_arb_n
    import mux_pkg::*;
#(
    parameter  int LARGURA = LARGURA_PADRAO,
    parameter  int CANAIS  = 4,
    localparam int SEL_W   = $clog2(CANAIS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      modo,
    input  logic [SEL_W-1:0]          controle,
    input  logic [CANAIS*LARGURA-1:0] entrada,
    input  logic [CANAIS-1:0]         entrada_valida,
    output logic [CANAIS-1:0]         entrada_pronta,
    output logic [LARGURA-1:0]        saida,
    output logic                      saida_valida,
    input  logic                      saida_pronta,
    output logic [SEL_W-1:0]          canal_saida
`ifdef MUX_ARB_CONTADORES_EN
    ,
    output logic [CANAIS*CONT_W-1:0]  contagem
`endif
);

    logic [SEL_W-1:0]  ptr;
    logic [CANAIS-1:0] rr_concede;
    logic [SEL_W-1:0]  rr_indice;
    logic              rr_tem;
    logic              aceita;
    logic              tem_g;
    logic [SEL_W-1:0]  g;
    logic [CANAIS-1:0] g_onehot;
    logic              transferencia;

    rr_arbitro #(
        .CANAIS (CANAIS)
    ) u_rr (
        .pedido        (entrada_valida),
        .ptr           (ptr),
        .concede       (rr_concede),
        .indice        (rr_indice),
        .tem_concessao (rr_tem)
    );

    // Output register can take a word when empty or being drained this cycle
    assign aceita        = !saida_valida || saida_pronta;
    assign transferencia = tem_g && aceita;

    // Grant selection for the current mode; an out-of-range or idle controle yields no grant
    always_comb begin
        tem_g    = 1'b0;
        g        = '0;
        g_onehot = '0;
        if (modo == MODO_FIXO) begin
            if ((int'(controle) < CANAIS) && entrada_valida[controle]) begin
                tem_g              = 1'b1;
                g                  = controle;
                g_onehot[controle] = 1'b1;
            end
        end else begin
            tem_g    = rr_tem;
            g        = rr_indice;
            g_onehot = rr_concede;
        end
    end

    // Ready goes only to the granted channel, and only when the output can accept
    always_comb begin
        entrada_pronta = '0;
        if (transferencia) begin
            entrada_pronta = g_onehot;
        end
    end

    // Output stage and round-robin pointer; reset wins over any same-cycle transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            saida        <= '0;
            saida_valida <= 1'b0;
            canal_saida  <= '0;
            ptr          <= SEL_W'(CANAIS - 1);
        end else if (transferencia) begin
            saida        <= entrada[int'(g)*LARGURA +: LARGURA];
            saida_valida <= 1'b1;
            canal_saida  <= g;
            ptr          <= g;
        end else if (saida_pronta) begin
            saida_valida <= 1'b0;
        end
    end

`ifdef MUX_ARB_CONTADORES_EN
    // Per-channel accepted-transfer counters, saturating at CONT_MAX
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else if (transferencia) begin
            for (int i = 0; i < CANAIS; i++) begin
                if ((g == SEL_W'(i)) && (contagem[i*CONT_W +: CONT_W] != CONT_MAX)) begin
                    contagem[i*CONT_W +: CONT_W] <= contagem[i*CONT_W +: CONT_W] + CONT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: directed scenarios then random traffic against a transaction-level model.
// Latency: model expects a word one clock after its handshake.
// Backpressure: random saida_pronta exercises stall, drain and reset-mid-stall.
module tb_mux_arb_n;
    import mux_pkg::*;

    localparam int LARGURA = 32;
    localparam int CANAIS  = 4;
    localparam int SEL_W   = $clog2(CANAIS);

    logic                      clock;
    logic                      reset;
    logic                      modo;
    logic [SEL_W-1:0]          controle;
    logic [CANAIS*LARGURA-1:0] entrada;
    logic [CANAIS-1:0]         entrada_valida;
    logic [CANAIS-1:0]         entrada_pronta;
    logic [LARGURA-1:0]        saida;
    logic                      saida_valida;
    logic                      saida_pronta;
    logic [SEL_W-1:0]          canal_saida;
`ifdef MUX_ARB_CONTADORES_EN
    logic [CANAIS*CONT_W-1:0]  contagem;
`endif

    mux_arb_n #(
        .LARGURA (LARGURA),
        .CANAIS  (CANAIS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .modo           (modo),
        .controle       (controle),
        .entrada        (entrada),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .saida          (saida),
        .saida_valida   (saida_valida),
        .saida_pronta   (saida_pronta),
        .canal_saida    (canal_saida)
`ifdef MUX_ARB_CONTADORES_EN
        ,
        .contagem       (contagem)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vetores = 0;
    int erros   = 0;

    // Model state: contents of the output register plus the priority pointer
    bit               m_valid;
    logic [LARGURA-1:0] m_data;
    int               m_ch;
    int               m_ptr;
    int               m_cnt [CANAIS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vetores++;
        assert (obs === exp) else begin
            erros++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which channel the rules say is served given current inputs and model pointer
    function automatic void escolhe(output bit tem, output int c);
        tem = 1'b0;
        c   = 0;
        if (modo == MODO_FIXO) begin
            if (int'(controle) < CANAIS && entrada_valida[controle]) begin
                tem = 1'b1;
                c   = int'(controle);
            end
        end else begin
            for (int k = 1; k <= CANAIS; k++) begin
                if (!tem && entrada_valida[(m_ptr + k) % CANAIS]) begin
                    tem = 1'b1;
                    c   = (m_ptr + k) % CANAIS;
                end
            end
        end
    endfunction

    task automatic ciclo(input bit checa_saida);
        bit               tem;
        int               c;
        bit               pode;
        logic [CANAIS-1:0] exp_rdy;
        @(negedge clock);
        pode = !m_valid || saida_pronta;
        escolhe(tem, c);
        exp_rdy = '0;
        if (tem && pode) exp_rdy[c] = 1'b1;
        if (!reset) chk("entrada_pronta", 64'(entrada_pronta), 64'(exp_rdy));
        @(posedge clock);
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = CANAIS - 1;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else if (tem && pode) begin
            m_valid = 1'b1;
            m_data  = entrada[c*LARGURA +: LARGURA];
            m_ch    = c;
            m_ptr   = c;
            if (m_cnt[c] < 65535) m_cnt[c]++;
        end else if (m_valid && saida_pronta) begin
            m_valid = 1'b0;
        end
        #1;
        if (checa_saida) begin
            chk("saida_valida", 64'(saida_valida), 64'(m_valid));
            chk("saida", 64'(saida), 64'(m_data));
            chk("canal_saida", 64'(canal_saida), 64'(m_ch));
`ifdef MUX_ARB_CONTADORES_EN
            for (int i = 0; i < CANAIS; i++)
                chk("contagem", 64'(contagem[i*CONT_W +: CONT_W]), 64'(m_cnt[i]));
`endif
        end
    endtask

    task automatic dados_aleatorios();
        for (int i = 0; i < CANAIS; i++) entrada[i*LARGURA +: LARGURA] = $urandom;
    endtask

    int seq_rr [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = CANAIS - 1;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        reset = 1'b1; modo = MODO_FIXO; controle = '0; entrada_valida = '0;
        saida_pronta = 1'b0; dados_aleatorios();

        // Reset state
        ciclo(1'b1);
        chk("reset_saida_valida", 64'(saida_valida), 64'd0);
        reset = 1'b0;

        // Fixed select of channel 2
        modo = MODO_FIXO; controle = 2'd2; entrada_valida = 4'b1111; saida_pronta = 1'b1;
        dados_aleatorios(); entrada[2*LARGURA +: LARGURA] = 32'hDEADBEEF;
        ciclo(1'b1);
        chk("fixo_saida", 64'(saida), 64'hDEADBEEF);
        chk("fixo_canal", 64'(canal_saida), 64'd2);

        // Fixed select of an idle channel: no grant, register drains
        controle = 2'd1; entrada_valida = 4'b1101; dados_aleatorios();
        ciclo(1'b1);
        chk("fixo_ocioso_valida", 64'(saida_valida), 64'd0);

        // Round-robin from reset: 0,1,2,3,0,1
        reset = 1'b1; ciclo(1'b1); reset = 1'b0;
        modo = MODO_RR; entrada_valida = 4'b1111; saida_pronta = 1'b1;
        for (int n = 0; n < 6; n++) begin
            dados_aleatorios();
            ciclo(1'b1);
            chk("rr_sequencia", 64'(canal_saida), 64'(seq_rr[n]));
        end

        // Only channel 3 valid, 3-clock stall, then release
        entrada_valida = 4'b1000; dados_aleatorios();
        ciclo(1'b1);
        chk("so3_canal", 64'(canal_saida), 64'd3);
        saida_pronta = 1'b0;
        for (int n = 0; n < 3; n++) begin
            dados_aleatorios();
            ciclo(1'b1);
            chk("stall_canal", 64'(canal_saida), 64'd3);
        end
        saida_pronta = 1'b1;
        for (int n = 0; n < 3; n++) begin
            dados_aleatorios();
            ciclo(1'b1);
        end

        // Reset while stalled discards the held word
        saida_pronta = 1'b0; dados_aleatorios();
        ciclo(1'b1);
        reset = 1'b1;
        ciclo(1'b1);
        chk("reset_stall_saida", 64'(saida), 64'd0);
        chk("reset_stall_valida", 64'(saida_valida), 64'd0);
        chk("reset_stall_canal", 64'(canal_saida), 64'd0);
        reset = 1'b0;

        // Random traffic in both modes, including out-of-range controle and rare resets
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 199) == 0);
            modo           = $urandom_range(0, 1) == 1;
            controle       = SEL_W'($urandom);
            entrada_valida = CANAIS'($urandom);
            saida_pronta   = ($urandom_range(0, 3) != 0);
            dados_aleatorios();
            ciclo(1'b1);
        end
        reset = 1'b0;

`ifdef MUX_ARB_CONTADORES_EN
        // Saturation: 70000 transfers on channel 1
        reset = 1'b1; ciclo(1'b1); reset = 1'b0;
        modo = MODO_FIXO; controle = 2'd1; entrada_valida = 4'b0010; saida_pronta = 1'b1;
        for (int n = 0; n < 70000; n++) ciclo(1'b0);
        #1;
        chk("contagem_sat_1", 64'(contagem[1*CONT_W +: CONT_W]), 64'hFFFF);
        chk("contagem_0", 64'(contagem[0 +: CONT_W]), 64'd0);
        chk("contagem_2", 64'(contagem[2*CONT_W +: CONT_W]), 64'd0);
        chk("contagem_3", 64'(contagem[3*CONT_W +: CONT_W]), 64'd0);
        reset = 1'b1; ciclo(1'b1); reset = 1'b0;
        chk("contagem_reset", 64'(contagem), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised successor to the 2-input 32b/5b datapath muxes.
- Selects one of CANAIS valid/ready source channels of LARGURA bits and delivers it through a registered valid/ready output stage.
- Two selection modes: fixed select from `controle`, or round-robin arbitration.
- Used wherever several producers share one datapath consumer, e.g. writeback or memory-request sharing in the MIPS_FPGA datapath.

Parameters:
- LARGURA, 32, data width per channel.
- CANAIS, 4, number of input channels (2..16).
- SEL_W, $clog2(CANAIS), localparam, width of channel index; not overridable.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- modo  in  1  0 = fixed select, 1 = round-robin.
- controle  in  SEL_W  channel index used when modo=0.
- entrada  in  CANAIS*LARGURA  flat data; channel i at [i*LARGURA +: LARGURA].
- entrada_valida  in  CANAIS  per-channel valid.
- entrada_pronta  out  CANAIS  per-channel ready (one-hot or zero).
- saida  out  LARGURA  registered output data.
- saida_valida  out  1  output valid.
- saida_pronta  in  1  consumer ready.
- canal_saida  out  SEL_W  index of the channel that produced saida.

Behaviour:
- Reset (synchronous, clock edge with reset=1): saida=0, saida_valida=0, canal_saida=0, round-robin pointer ptr=CANAIS-1. Reset overrides any transfer in the same cycle; a held output word is discarded.
- Output stage: single-entry register.
  - aceita = !saida_valida | saida_pronta (empty, or draining this cycle).
- Grant (combinational):
  - modo=0: g=controle if entrada_valida[controle]=1. controle>=CANAIS, or the selected channel not valid, gives no grant.
  - modo=1: g = first valid channel scanning ptr+1, ptr+2, ... modulo CANAIS. After reset, channel 0 has highest priority. No valid channel gives no grant.
- entrada_pronta[g] = aceita when a grant exists; every other bit is 0. Ready may depend on valid; sources must not make valid depend on ready.
- Transfer on channel g at the clock edge where entrada_valida[g] & entrada_pronta[g]:
  - saida <= entrada[g]
  - canal_saida <= g
  - saida_valida <= 1
  - ptr <= g (ptr updates on transfers in both modes)
- Drain without new grant: saida_valida & saida_pronta with no grant → saida_valida <= 0. saida and canal_saida keep their last values.
- Stall: saida_valida & !saida_pronta → saida and canal_saida held stable; all entrada_pronta = 0.
- Latency: 1 clock from input handshake to saida_valida. Sustained throughput is 1 word/clock when saida_pronta stays high.
- Mode or controle changes take effect on the next grant evaluation; a word already in the register is unaffected.
- Data is passed unmodified; no width conversion.

Optional Feature:
- Macro: MUX_ARB_CONTADORES_EN.
- Defined:
  - Adds output port `contagem`, CANAIS*16 bits; channel i at [i*16 +: 16].
  - Each field counts accepted transfers of its channel and saturates at 16'hFFFF (no wrap).
  - Cleared to 0 on reset; increments in the transfer cycle.
- Undefined: port and counters absent; otherwise identical behaviour.

Decomposition:
- Package mux_pkg:
  - MODO_FIXO=1'b0, MODO_RR=1'b1
  - CONT_W=16, CONT_MAX=16'hFFFF
  - default LARGURA=32
- Sub-module rr_arbitro (CANAIS):
  - inputs: pedido[CANAIS], ptr
  - outputs: concede one-hot, indice, tem_concessao
  - ptr register stays in mux_arb_n.

Test Plan:
- Reset mid-stall: saida_valida=1, saida_pronta=0, assert reset → next clock saida=0, saida_valida=0, canal_saida=0, ptr=3.
- modo=0, controle=2, entrada_valida=4'b1111, ch2=32'hDEADBEEF, saida_pronta=1 → entrada_pronta=4'b0100; next clock saida=DEADBEEF, canal_saida=2.
- modo=0, controle=1, entrada_valida=4'b1101 → entrada_pronta=0, saida_valida falls after drain.
- modo=1, all 4 valid continuously, saida_pronta=1 → canal_saida sequence 0,1,2,3,0,1 on consecutive clocks.
- modo=1, only ch3 valid, saida_pronta=0 for 3 clocks after first word → saida/canal_saida=3 held stable, entrada_pronta=0 during stall; on release, the next word follows with 1-clock latency and no loss or duplication.
- MUX_ARB_CONTADORES_EN defined: 70000 transfers on ch1 → contagem[31:16]=16'hFFFF, other fields 0; reset → all 0.
